run_length_adjust: RTL and testbench

Computes the residual of a JPEG-LS run-mode run count after the run-length coder has emitted its full-block segments. The residual is run_length minus the accumulated block sizes already coded (remainder_subtract_accum). It sits between the run counter / run-index (J-table) stage and the run-interruption encoder, which codes the remainder in J[RUNindex] bits. The result is registered, one cycle after the operands.

---
 rtl/run_length_adjust_pkg.sv | 21 ++
 rtl/run_length_adjust_sat_sub.sv | 19 +
 rtl/run_length_adjust.sv | 53 +++++
 tb/tb_run_length_adjust.sv | 162 ++++++++++++++++
 4 files changed

// File: rtl/run_length_adjust_pkg.sv
// Shared JPEG-LS run-mode parameters: count widths and the run-index (J) table
// used by the run counter, this residual stage and the run-interruption encoder.
package run_length_adjust_pkg;

    localparam int runcount_length = 16;
    localparam int runindex_length = 5;
    localparam int J_TABLE_SIZE    = 32;

    // J[RUNindex]: each full block coded in run mode covers 1 << J samples
    localparam logic [3:0] J_TABLE [0:J_TABLE_SIZE-1] = '{
        4'd0,  4'd0,  4'd0,  4'd0,  4'd1,  4'd1,  4'd1,  4'd1,
        4'd2,  4'd2,  4'd2,  4'd2,  4'd3,  4'd3,  4'd3,  4'd3,
        4'd4,  4'd4,  4'd5,  4'd5,  4'd6,  4'd6,  4'd7,  4'd7,
        4'd8,  4'd9,  4'd10, 4'd11, 4'd12, 4'd13, 4'd14, 4'd15
    };

    function automatic int unsigned j_block_len(input logic [runindex_length-1:0] idx);
        return 32'd1 << J_TABLE[idx];
    endfunction

endpackage

// File: rtl/run_length_adjust_sat_sub.sv
// Unsigned saturating subtractor: a - b clamped at zero, with a borrow flag
// raised whenever b exceeds a.
module run_length_adjust_sat_sub #(
    parameter int W = 16
) (
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic [W-1:0] diff,
    output logic         borrow
);

    logic [W:0] w_wide_diff;

    // One extra bit so the MSB of the wide result is the borrow
    assign w_wide_diff = {1'b0, a} - {1'b0, b};
    assign borrow      = w_wide_diff[W];
    assign diff        = w_wide_diff[W] ? '0 : w_wide_diff[W-1:0];

endmodule

// File: rtl/run_length_adjust.sv
// JPEG-LS run residual: run_length minus the block lengths already coded,
// saturated at zero, registered one cycle after the operands.
module run_length_adjust
    import run_length_adjust_pkg::*;
#(
    parameter int runcount_length = run_length_adjust_pkg::runcount_length
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       in_valid,
    input  logic [runcount_length-1:0] run_length,
    input  logic [runcount_length-1:0] remainder_subtract_accum,
    output logic                       out_valid,
    output logic [runcount_length-1:0] run_length_remainder,
    output logic                       underflow
);

    logic [runcount_length-1:0] w_diff;
    logic                       w_borrow;

    logic                       r_out_valid;
    logic [runcount_length-1:0] r_remainder;
    logic                       r_underflow;

    run_length_adjust_sat_sub #(
        .W (runcount_length)
    ) u_sat_sub (
        .a      (run_length),
        .b      (remainder_subtract_accum),
        .diff   (w_diff),
        .borrow (w_borrow)
    );

    // Result fields only load on valid operands so they hold across idle cycles
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_out_valid <= 1'b0;
            r_remainder <= '0;
            r_underflow <= 1'b0;
        end else begin
            r_out_valid <= in_valid;
            if (in_valid) begin
                r_remainder <= w_diff;
                r_underflow <= w_borrow;
            end
        end
    end

    assign out_valid            = r_out_valid;
    assign run_length_remainder = r_remainder;
    assign underflow            = r_underflow;

endmodule

// File: tb/tb_run_length_adjust.sv
// Directed and randomized checks of run_length_adjust against an arithmetic
// reference of the saturating run residual.
module tb_run_length_adjust;
    import run_length_adjust_pkg::*;

    localparam int W = 16;

    logic         clk = 1'b0;
    logic         reset_n;
    logic         in_valid;
    logic [W-1:0] run_length;
    logic [W-1:0] accum;
    logic         out_valid;
    logic [W-1:0] remainder;
    logic         underflow;

    int pass_count  = 0;
    int check_count = 0;

    logic [W-1:0] last_rem;
    logic         last_uf;

    always #5 clk = ~clk;

    run_length_adjust #(
        .runcount_length (W)
    ) dut (
        .clk                      (clk),
        .reset_n                  (reset_n),
        .in_valid                 (in_valid),
        .run_length               (run_length),
        .remainder_subtract_accum (accum),
        .out_valid                (out_valid),
        .run_length_remainder     (remainder),
        .underflow                (underflow)
    );

    function automatic logic [W-1:0] ref_rem(input int unsigned a, input int unsigned b);
        return (a > b) ? W'(a - b) : '0;
    endfunction

    function automatic logic ref_uf(input int unsigned a, input int unsigned b);
        return b > a;
    endfunction

    task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
        check_count++;
        assert (obs === exp) pass_count++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive(input logic v, input logic [W-1:0] rl, input logic [W-1:0] acc);
        in_valid   = v;
        run_length = rl;
        accum      = acc;
        @(posedge clk);
        #1;
    endtask

    // One valid transaction, checked on the following cycle
    task automatic txn(input string tag, input int unsigned rl, input int unsigned acc);
        drive(1'b1, W'(rl), W'(acc));
        last_rem = ref_rem(rl, acc);
        last_uf  = ref_uf(rl, acc);
        $display("txn %s rl=%0d acc=%0d rem=%0d uf=%0b vld=%0b", tag, rl, acc, remainder, underflow, out_valid);
        check({tag, "_valid"}, W'(out_valid), W'(1'b1));
        check({tag, "_rem"},   remainder,     last_rem);
        check({tag, "_uf"},    W'(underflow), W'(last_uf));
    endtask

    task automatic idle(input string tag);
        drive(1'b0, 'x, 'x);
        $display("idle %s rem=%0d uf=%0b vld=%0b", tag, remainder, underflow, out_valid);
        check({tag, "_valid"}, W'(out_valid), W'(1'b0));
        check({tag, "_rem"},   remainder,     last_rem);
        check({tag, "_uf"},    W'(underflow), W'(last_uf));
    endtask

    initial begin
        int unsigned rl, acc, blk, stop_idx;

        // Reset held with live operands on the bus
        reset_n    = 1'b0;
        in_valid   = 1'b1;
        run_length = W'($urandom);
        accum      = W'($urandom);
        #1;
        check("rst_async_valid", W'(out_valid), W'(1'b0));
        repeat (2) drive(1'b1, W'($urandom), W'($urandom));
        check("rst_valid", W'(out_valid), W'(1'b0));
        check("rst_rem",   remainder,     '0);
        check("rst_uf",    W'(underflow), W'(1'b0));
        reset_n = 1'b1;

        txn("normal", 37, 32);
        last_rem = 5; last_uf = 0;
        idle("normal_pulse");

        txn("zero_zero", 0, 0);
        txn("max_zero", 65535, 0);
        txn("equal", 4096, 4096);
        txn("underflow", 3, 8);
        idle("underflow_hold");

        txn("stream0", 10, 8);
        txn("stream1", 100, 64);
        txn("stream2", 7, 0);
        idle("stream_hold");

        // Mid-stream reset discards the in-flight result at once
        txn("pre_reset", 500, 20);
        in_valid   = 1'b1;
        run_length = 16'd900;
        accum      = 16'd1;
        #2 reset_n = 1'b0;
        #1;
        check("midrst_valid", W'(out_valid), W'(1'b0));
        check("midrst_rem",   remainder,     '0);
        check("midrst_uf",    W'(underflow), W'(1'b0));
        drive(1'b1, 16'd900, 16'd1);
        check("midrst_held_valid", W'(out_valid), W'(1'b0));
        reset_n  = 1'b1;
        last_rem = '0;
        last_uf  = 1'b0;
        idle("post_reset_idle");
        txn("post_reset_first", 900, 1);

        // Well-formed vectors: accumulator is a prefix sum of J-table blocks
        for (int n = 0; n < 150; n++) begin
            rl       = $urandom_range(0, 65535);
            stop_idx = $urandom_range(0, J_TABLE_SIZE - 1);
            acc      = 0;
            for (int k = 0; k < J_TABLE_SIZE; k++) begin
                blk = j_block_len(5'(k));
                if (k >= stop_idx || acc + blk > rl) break;
                acc += blk;
            end
            txn("vector", rl, acc);
        end

        // Unconstrained operands with random idle gaps
        for (int n = 0; n < 150; n++) begin
            if ($urandom_range(0, 3) == 0) begin
                idle("rand_gap");
            end else begin
                rl  = $urandom_range(0, 65535);
                acc = ($urandom_range(0, 7) == 0) ? rl : $urandom_range(0, 65535);
                txn("rand", rl, acc);
            end
        end

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "simulation time limit reached");
    end

endmodule
